dequant_engine: RTL and testbench

Parametrised, table-driven inverse quantizer for the JPEG decode path. Accepts one N-coefficient column per handshake, multiplies each lane by an entry from a runtime-loadable quantization table, then saturates and emits the result with valid/ready backpressure. It sits between the entropy/zig-zag stage and the column IDCT, replacing the fixed-constant, fixed-table, no-backpressure dequantizer.

---
 rtl/dequant_engine.sv | 137 +++++++++++++
 tb/tb_dequant_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequant_engine.sv
// Table-driven JPEG inverse quantizer: two-stage multiply/reduce pipeline with valid/ready flow control.
// Optional build macro DEQUANT_SAT_EN clamps each lane to OUT_W bits; without it lanes wrap.
module dequant_engine #(
    parameter int COEF_W     = 12,
    parameter int OUT_W      = 12,
    parameter int Q_W        = 8,
    parameter int N          = 8,
    parameter int NUM_TABLES = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic [N*COEF_W-1:0]                   column_in,
    input  logic [$clog2(NUM_TABLES)-1:0]         table_sel_in,
    input  logic                                  valid_in,
    output logic                                  ready_out,
    output logic [N*OUT_W-1:0]                    column_out,
    output logic                                  last_out,
    output logic                                  sat_out,
    output logic                                  valid_out,
    input  logic                                  ready_in,
    input  logic                                  tbl_wr_en_in,
    input  logic [$clog2(NUM_TABLES*N*N)-1:0]     tbl_addr_in,
    input  logic [Q_W-1:0]                        tbl_data_in
);
    localparam int P_W = COEF_W + Q_W + 1;
    localparam int AW  = $clog2(NUM_TABLES*N*N);
    localparam int CW  = $clog2(N);
    localparam int SW  = $clog2(NUM_TABLES);
`ifdef DEQUANT_SAT_EN
    localparam int S1_W = P_W;
    localparam logic signed [P_W-1:0] SAT_HI = P_W'(2**(OUT_W-1) - 1);
    localparam logic signed [P_W-1:0] SAT_LO = ~SAT_HI;
`else
    // Wrapping only needs the low OUT_W product bits, so stage 1 keeps just those.
    localparam int S1_W = OUT_W;
`endif

    logic [Q_W-1:0]          q_mem [NUM_TABLES*N*N];
    logic [CW-1:0]           col_cnt;
    logic [SW-1:0]           tbl_latch;
    logic [SW-1:0]           tbl_cur;
    logic                    en;
    logic                    accept;
    logic [AW-1:0]           rd_addr [N];
    logic signed [P_W-1:0]   coef_x  [N];
    logic signed [P_W-1:0]   q_x     [N];
    logic signed [S1_W-1:0]  prod_c  [N];
    logic signed [S1_W-1:0]  s1_prod [N];
    logic                    s1_valid;
    logic                    s1_last;
    logic [N*OUT_W-1:0]      red_col;
    logic                    red_sat;

    // Handshake: a column moves on valid_in && ready_out; ready_out = !valid_out || ready_in.
    assign en        = !valid_out || ready_in;
    assign ready_out = en;
    assign accept    = valid_in && en;
    assign tbl_cur   = (col_cnt == '0) ? table_sel_in : tbl_latch;

    // Table RAM is not reset; a same-cycle read sees the old entry.
    always_ff @(posedge clk_in) begin
        if (tbl_wr_en_in) begin
            q_mem[tbl_addr_in] <= tbl_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            col_cnt   <= '0;
            tbl_latch <= '0;
        end else if (accept) begin
            if (col_cnt == '0) begin
                tbl_latch <= table_sel_in;
            end
            col_cnt <= (col_cnt == CW'(N-1)) ? '0 : col_cnt + CW'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rd_addr[k] = AW'(int'(tbl_cur)*N*N + int'(col_cnt)*N + k);
            coef_x[k]  = P_W'($signed(column_in[k*COEF_W +: COEF_W]));
            q_x[k]     = $signed(P_W'({1'b0, q_mem[rd_addr[k]]}));
            prod_c[k]  = S1_W'(coef_x[k] * q_x[k]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                s1_prod[k] <= '0;
            end
        end else if (en) begin
            s1_valid <= valid_in;
            s1_last  <= valid_in && (col_cnt == CW'(N-1));
            for (int k = 0; k < N; k++) begin
                s1_prod[k] <= valid_in ? prod_c[k] : '0;
            end
        end
    end

    always_comb begin
        red_col = '0;
        red_sat = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef DEQUANT_SAT_EN
            if (s1_prod[k] > SAT_HI) begin
                red_col[k*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
                red_sat = 1'b1;
            end else if (s1_prod[k] < SAT_LO) begin
                red_col[k*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
                red_sat = 1'b1;
            end else begin
                red_col[k*OUT_W +: OUT_W] = s1_prod[k][OUT_W-1:0];
            end
`else
            red_col[k*OUT_W +: OUT_W] = s1_prod[k];
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_out  <= 1'b0;
            column_out <= '0;
            last_out   <= 1'b0;
            sat_out    <= 1'b0;
        end else if (en) begin
            valid_out  <= s1_valid;
            column_out <= s1_valid ? red_col : '0;
            last_out   <= s1_valid && s1_last;
            sat_out    <= s1_valid && red_sat;
        end
    end
endmodule

// File: tb/tb_dequant_engine.sv
// Directed bench for dequant_engine: an arithmetic reference model feeds an expected queue that is
// compared against the outputs every cycle, plus literal probes of lanes 0/1 after selected blocks.
module tb_dequant_engine;
    localparam int COEF_W     = 12;
    localparam int OUT_W      = 12;
    localparam int Q_W        = 8;
    localparam int N          = 8;
    localparam int NUM_TABLES = 2;
    localparam int AW         = $clog2(NUM_TABLES*N*N);
    localparam int SW         = $clog2(NUM_TABLES);
    localparam int EW         = N*OUT_W + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N*COEF_W-1:0]  column_in;
    logic [SW-1:0]        table_sel_in;
    logic                 valid_in;
    logic                 ready_out;
    logic [N*OUT_W-1:0]   column_out;
    logic                 last_out;
    logic                 sat_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 tbl_wr_en;
    logic [AW-1:0]        tbl_addr;
    logic [Q_W-1:0]       tbl_data;

    always #5 clk = ~clk;

    dequant_engine #(
        .COEF_W(COEF_W), .OUT_W(OUT_W), .Q_W(Q_W), .N(N), .NUM_TABLES(NUM_TABLES)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .column_in(column_in), .table_sel_in(table_sel_in),
        .valid_in(valid_in), .ready_out(ready_out), .column_out(column_out), .last_out(last_out),
        .sat_out(sat_out), .valid_out(valid_out), .ready_in(ready_in), .tbl_wr_en_in(tbl_wr_en),
        .tbl_addr_in(tbl_addr), .tbl_data_in(tbl_data)
    );

    int             n_vec  = 0;
    int             n_miss = 0;
    logic [Q_W-1:0] shadow [NUM_TABLES*N*N];
    logic [EW-1:0]  exp_q[$];
    logic [EW-1:0]  exp_head;
    int             m_col = 0;
    int             m_tbl = 0;
    bit             started = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [N*COEF_W-1:0] make_col(input int base, input int step);
        logic [N*COEF_W-1:0] v = '0;
        for (int k = 0; k < N; k++) begin
            int x = base + k*step;
            v[k*COEF_W +: COEF_W] = x[COEF_W-1:0];
        end
        return v;
    endfunction

    // Reference: lane value * table entry, then clamp or wrap to OUT_W bits.
    function automatic logic [EW-1:0] model_col(input logic [N*COEF_W-1:0] col, input int tbl, input int cidx);
        logic [N*OUT_W-1:0] lanes = '0;
        logic               sat   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int c = $signed(col[k*COEF_W +: COEF_W]);
            int p = c * int'(shadow[tbl*N*N + cidx*N + k]);
            int r = p;
`ifdef DEQUANT_SAT_EN
            if (p > 2**(OUT_W-1) - 1) begin
                r = 2**(OUT_W-1) - 1;
                sat = 1'b1;
            end else if (p < -(2**(OUT_W-1))) begin
                r = -(2**(OUT_W-1));
                sat = 1'b1;
            end
`endif
            lanes[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
        return {lanes, (cidx == N-1), sat};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_col = 0;
            m_tbl = 0;
        end else if (valid_in && ready_out) begin
            if (m_col == 0) m_tbl = int'(table_sel_in);
            exp_q.push_back(model_col(column_in, m_tbl, m_col));
            m_col = (m_col + 1) % N;
        end
        if (tbl_wr_en) shadow[tbl_addr] = tbl_data;
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready_rule", 128'(ready_out), 128'(!valid_out || ready_in));
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 128'(valid_out), 128'(0));
                end else begin
                    exp_head = exp_q[0];
                    check("column_out", 128'(column_out), 128'(exp_head[EW-1:2]));
                    check("last_out", 128'(last_out), 128'(exp_head[1]));
                    check("sat_out", 128'(sat_out), 128'(exp_head[0]));
                    if (ready_in) void'(exp_q.pop_front());
                end
            end else begin
                check("bubble", 128'({column_out, last_out, sat_out}), 128'(0));
            end
        end
    end

    task automatic tbl_write(input int addr, input int data);
        tbl_wr_en = 1'b1;
        tbl_addr  = AW'(addr);
        tbl_data  = Q_W'(data);
        @(posedge clk); #1;
        tbl_wr_en = 1'b0;
    endtask

    task automatic load_table(input int t, input int val);
        for (int i = 0; i < N*N; i++) tbl_write(t*N*N + i, val);
    endtask

    task automatic send_col(input logic [N*COEF_W-1:0] col, input int sel,
                            input bit wr = 1'b0, input int waddr = 0, input int wdata = 0);
        int b = 0;
        column_in    = col;
        table_sel_in = SW'(sel);
        valid_in     = 1'b1;
        if (wr) begin
            tbl_wr_en = 1'b1;
            tbl_addr  = AW'(waddr);
            tbl_data  = Q_W'(wdata);
        end
        @(negedge clk);
        while (!ready_out && b < 50) begin
            b++;
            @(negedge clk);
        end
        if (b >= 50) check("accept_timeout", 128'(ready_out), 128'(1));
        @(posedge clk); #1;
        valid_in  = 1'b0;
        tbl_wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !valid_out) break;
            @(negedge clk);
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    // Literal check of the first column of a block, launched just after its accept.
    task automatic probe(input string name, input int l0, input int l1, input bit s);
        @(negedge clk);
        check({name, "_lat1"}, 128'(valid_out), 128'(0));
        @(negedge clk);
        check({name, "_lat2"}, 128'(valid_out), 128'(1));
        check({name, "_lane0"}, 128'(column_out[OUT_W-1:0]), 128'(l0[OUT_W-1:0]));
        check({name, "_lane1"}, 128'(column_out[2*OUT_W-1:OUT_W]), 128'(l1[OUT_W-1:0]));
        check({name, "_sat"}, 128'(sat_out), 128'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*COEF_W-1:0] c0;
        rst_n = 1'b0; valid_in = 1'b0; column_in = '0; table_sel_in = '0;
        ready_in = 1'b1; tbl_wr_en = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_column", 128'(column_out), 128'(0));
        check("rst_last_sat", 128'({last_out, sat_out}), 128'(0));
        check("rst_ready", 128'(ready_out), 128'(1));
        rst_n = 1'b1;
        started = 1'b1;

        // Table 0 = 16, all lanes 3 -> 48, last on 8th column.
        load_table(0, 16);
        send_col(make_col(3, 0), 0);
        fork probe("t1", 48, 48, 1'b0); join_none
        for (int c = 1; c < N; c++) send_col(make_col(3, 0), 0);
        drain();

        // Table select latched on column 0 only.
        load_table(0, 1);
        load_table(1, 2);
        send_col(make_col(-35, 10), 1);
        fork probe("t2a", -70, -50, 1'b0); join_none
        for (int c = 1; c < N; c++) send_col(make_col(-35 + c, 10), 0);
        drain();
        send_col(make_col(-35, 10), 0);
        fork probe("t2b", -35, -25, 1'b0); join_none
        for (int c = 1; c < N; c++) send_col(make_col(40 - c, -9), 0);
        drain();

        // Downstream stall mid-block.
        fork
            begin
                repeat (3) @(posedge clk);
                #1 ready_in = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_ready", 128'(ready_out), 128'(0));
                end
                @(posedge clk); #1;
                ready_in = 1'b1;
            end
            for (int c = 0; c < N; c++) send_col(make_col(100*c - 300, -17), 0);
        join
        drain();

        // Saturation / wrap with Q = 99.
        load_table(1, 99);
        c0 = '0;
        c0[0 +: COEF_W]      = COEF_W'(2047);
        c0[COEF_W +: COEF_W] = COEF_W'(-2048);
        send_col(c0, 1);
`ifdef DEQUANT_SAT_EN
        fork probe("t4", 2047, -2048, 1'b1); join_none
`else
        fork probe("t4", 1949, -2048, 1'b0); join_none
`endif
        for (int c = 1; c < N; c++) send_col(make_col(500*c - 1700, 23), 1);
        drain();

        // Write to Q[0][0][0] in the same cycle column 0 reads it.
        load_table(0, 7);
        send_col(make_col(1, 0), 0, 1'b1, 0, 5);
        fork probe("t5a", 7, 7, 1'b0); join_none
        for (int c = 1; c < N; c++) send_col(make_col(1, 0), 0);
        drain();
        send_col(make_col(1, 0), 0);
        fork probe("t5b", 5, 7, 1'b0); join_none
        for (int c = 1; c < N; c++) send_col(make_col(1, 0), 0);
        drain();

        // Reset after 3 columns; next accept restarts the block and re-latches the table.
        load_table(0, 2);
        load_table(1, 3);
        for (int c = 0; c < 3; c++) send_col(make_col(10*c, 3), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 128'(valid_out), 128'(0));
        @(posedge clk); #1;
        send_col(make_col(5, 1), 1);
        fork probe("t6", 15, 18, 1'b0); join_none
        for (int c = 1; c < N; c++) send_col(make_col(5 + c, 1), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
